// File: rtl/fmc_port_arbiter_pkg.sv
// Shared definitions for the fast-memory port arbiter: state encoding,
// port count and the default ownership timeout.
package fmc_port_arbiter_pkg;

  localparam int FMC_NPORTS          = 4;
  localparam int FMC_TIMEOUT_CYC_DEF = 1023;

  typedef enum logic [1:0] {
    FMC_IDLE    = 2'd0,
    FMC_GRANT   = 2'd1,
    FMC_BUSY    = 2'd2,
    FMC_RECOVER = 2'd3
  } fmc_state_e;

endpackage

// File: rtl/fmc_port_arbiter_rr_pick4.sv
// Four-way round-robin picker. Searches upward from the port after the
// pointer, wrapping around, and returns the first requester. Purely
// combinational so it can be shared with the core memory arbiter.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       vld,
  output logic [1:0] idx
);

  logic [7:0] req_dbl_s;
  logic [3:0] req_rot_s;
  logic [2:0] base_s;
  logic [1:0] off_s;

  // Rotate the request so bit 0 is the port after the pointer, then take the lowest set bit.
  always_comb begin
    req_dbl_s = {req, req};
    base_s    = {1'b0, ptr} + 3'd1;
    req_rot_s = req_dbl_s[base_s +: 4];
    casez (req_rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    vld = |req;
    idx = ptr + 2'd1 + off_s;
  end

endmodule

// File: rtl/fmc_port_arbiter.sv
// Fast-memory ownership sequencer: grants one of four processor ports,
// holds the one-hot select for the whole memory cycle, and releases on
// cycle end, request withdrawal or timeout with a one-cycle recover step.
module fmc_port_arbiter
  import fmc_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = FMC_TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mc_rq_cyc_p0,
  input  logic         mc_rq_cyc_p1,
  input  logic         mc_rq_cyc_p2,
  input  logic         mc_rq_cyc_p3,
  input  logic         fmc_select_p0,
  input  logic         fmc_select_p1,
  input  logic         fmc_select_p2,
  input  logic         fmc_select_p3,
  input  logic [18:21] sel_p0,
  input  logic [18:21] sel_p1,
  input  logic [18:21] sel_p2,
  input  logic [18:21] sel_p3,
  input  logic [0:3]   memsel_p0,
  input  logic [0:3]   memsel_p1,
  input  logic [0:3]   memsel_p2,
  input  logic [0:3]   memsel_p3,
  input  logic [0:3]   port_en,
  input  logic         fmc_addr_ack,
  input  logic         fmc_cyc_done,
  output logic         fmc_p0_sel,
  output logic         fmc_p1_sel,
  output logic         fmc_p2_sel,
  output logic         fmc_p3_sel,
  output logic [0:1]   fmc_owner,
  output logic         fmc_busy,
  output logic         fmc_timeout
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);

  fmc_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [1:0]             owner_q, owner_d;
  logic [FMC_NPORTS-1:0]  sel_q, sel_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;

  logic [FMC_NPORTS-1:0]  rq_s;
  logic [FMC_NPORTS-1:0]  hold_s;
  logic                   owner_hold_s;
  logic                   expired_s;
  logic                   grant_s;
  logic                   expire_evt_s;
  logic                   pick_vld_s;
  logic [1:0]             pick_idx_s;

  // Qualify requests for arbitration; the owner's hold ignores memsel and enable so
  // mid-cycle configuration changes only matter at the next arbitration.
  always_comb begin
    rq_s[0]      = mc_rq_cyc_p0 & fmc_select_p0 & (sel_p0 == memsel_p0) & port_en[0];
    rq_s[1]      = mc_rq_cyc_p1 & fmc_select_p1 & (sel_p1 == memsel_p1) & port_en[1];
    rq_s[2]      = mc_rq_cyc_p2 & fmc_select_p2 & (sel_p2 == memsel_p2) & port_en[2];
    rq_s[3]      = mc_rq_cyc_p3 & fmc_select_p3 & (sel_p3 == memsel_p3) & port_en[3];
    hold_s[0]    = mc_rq_cyc_p0 & fmc_select_p0;
    hold_s[1]    = mc_rq_cyc_p1 & fmc_select_p1;
    hold_s[2]    = mc_rq_cyc_p2 & fmc_select_p2;
    hold_s[3]    = mc_rq_cyc_p3 & fmc_select_p3;
    owner_hold_s = hold_s[owner_q];
    expired_s    = (cnt_q == CNT_LIM);
  end

  rr_pick4 u_pick (
    .req (rq_s),
    .ptr (ptr_q),
    .vld (pick_vld_s),
    .idx (pick_idx_s)
  );

  // Register state, pointer, counter and all outputs; reset drops selects at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FMC_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      ptr_q     <= 2'd3;
      owner_q   <= 2'd0;
      sel_q     <= 4'b0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: ack beats withdrawal and timeout in GRANT, done beats timeout in BUSY.
  always_comb begin
    state_d      = state_q;
    grant_s      = 1'b0;
    expire_evt_s = 1'b0;
    case (state_q)
      FMC_IDLE: begin
        if (pick_vld_s) begin
          state_d = FMC_GRANT;
          grant_s = 1'b1;
        end else begin
          state_d = FMC_IDLE;
        end
      end
      FMC_GRANT: begin
        if (fmc_addr_ack) begin
          state_d = FMC_BUSY;
        end else if (!owner_hold_s) begin
          state_d = FMC_RECOVER;
        end else if (expired_s) begin
          state_d      = FMC_RECOVER;
          expire_evt_s = 1'b1;
        end else begin
          state_d = FMC_GRANT;
        end
      end
      FMC_BUSY: begin
        if (fmc_cyc_done) begin
          state_d = FMC_RECOVER;
        end else if (expired_s) begin
          state_d      = FMC_RECOVER;
          expire_evt_s = 1'b1;
        end else begin
          state_d = FMC_BUSY;
        end
      end
      FMC_RECOVER: state_d = FMC_IDLE;
      default:     state_d = FMC_IDLE;
    endcase
  end

  // Output and datapath: load owner/pointer at grant, run the saturating counter, derive selects.
  always_comb begin
    if (grant_s) begin
      ptr_d   = pick_idx_s;
      owner_d = pick_idx_s;
    end else begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
    end
    if ((state_q == FMC_GRANT) || (state_q == FMC_BUSY)) begin
      if (expired_s) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    busy_d = (state_d != FMC_IDLE);
    if (busy_d) begin
      sel_d = 4'b0001 << owner_d;
    end else begin
      sel_d = 4'b0000;
    end
    timeout_d = expire_evt_s;
  end

  assign fmc_p0_sel  = sel_q[0];
  assign fmc_p1_sel  = sel_q[1];
  assign fmc_p2_sel  = sel_q[2];
  assign fmc_p3_sel  = sel_q[3];
  assign fmc_owner   = owner_q;
  assign fmc_busy    = busy_q;
  assign fmc_timeout = timeout_q;

endmodule
